// File: rtl/rv_pkg.sv
// Shared helpers for the core: select-width sizing
// and one-hot to index conversion.
package rv_pkg;

  // Index width for an n-way select, never below one bit
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Position of the set bit in a one-hot vector (0 if none)
  function automatic int oh2idx(input logic [63:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++)
      if (oh[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// Producer/consumer handshake bundle of the
// round-robin mux; slave side faces the mux.
interface rr_mux_n_if
  import rv_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  localparam int SEL_W = sel_w(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               force_en;
  logic [SEL_W-1:0]   force_sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, force_en,
    output force_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, force_en,
    input  force_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_mux_n_arb.sv
// Round-robin arbiter: rotate requests, pick the
// lowest, rotate the one-hot grant back.
module rr_arbiter
  import rv_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] last_i,
  output logic [N-1:0]     grant_o
);

  logic [SEL_W:0] start;
  logic [N-1:0]   rot;
  logic [N-1:0]   iso;
  int             back;

  // Search begins one past the last winner, wrapping at N
  always_comb begin
    start = {1'b0, last_i} + (SEL_W+1)'(1);
    if (start >= (SEL_W+1)'(N))
      start = '0;
    back    = N - int'(start);
    rot     = N'({req_i, req_i} >> start);
    iso     = rot & (~rot + N'(1));
    grant_o = N'({iso, iso} >> back);
  end

endmodule

// File: rtl/rr_mux_n.sv
// N-way round-robin mux with force select and a
// single registered output stage (no skid buffer).
module rr_mux_n
  import rv_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  rr_mux_n_if.slave  bus
);

  localparam int SEL_W = sel_w(N);

  logic [N-1:0]     arb_gnt;
  logic [N-1:0]     frc_gnt;
  logic [N-1:0]     gnt;
  logic             can_load;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req_i   (bus.in_valid),
    .last_i  (last_q),
    .grant_o (arb_gnt)
  );

  // Grant selection: forced channel or arbiter winner
  always_comb begin
    can_load = !valid_q || bus.out_ready;
    frc_gnt  = '0;
    for (int i = 0; i < N; i++)
      frc_gnt[i] = bus.in_valid[i] &&
                   (bus.force_sel == SEL_W'(i));
    gnt = '0;
    if (can_load)
      gnt = bus.force_en ? frc_gnt : arb_gnt;
  end

  // AND-OR data mux keyed by the one-hot grant
  always_comb begin
    gnt_idx  = SEL_W'(oh2idx(64'(gnt)));
    gnt_data = '0;
    for (int i = 0; i < N; i++)
      gnt_data = gnt_data |
        (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N-1);
    end else if (|gnt) begin
      valid_q <= 1'b1;
      data_q  <= gnt_data;
      sel_q   <= gnt_idx;
      last_q  <= gnt_idx;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = gnt;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: vector table, corner
// sequences and a randomized reference model.
module tb_rr_mux_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_n_if #(.N(4), .WIDTH(32)) b4 ();
  rr_mux_n_if #(.N(3), .WIDTH(8))  b3 ();

  rr_mux_n #(.N(4), .WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  rr_mux_n #(.N(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        fen;
    logic [1:0]  fsel;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  os;
    logic [31:0] od;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  int          m_lg;
  bit          m_v;
  logic [31:0] m_d;
  int          m_s;

  function automatic int pick(input logic [3:0] v,
                              input bit fen,
                              input int fsel,
                              input bit ordy);
    if (m_v && !ordy) return -1;
    if (fen) return (fsel < 4 && v[fsel]) ? fsel : -1;
    for (int k = 1; k <= 4; k++)
      if (v[(m_lg + k) % 4]) return (m_lg + k) % 4;
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    b4.in_valid = '0; b4.in_data = '0;
    b4.force_en = 1'b0; b4.force_sel = '0;
    b4.out_ready = 1'b1;
    b3.in_valid = '0; b3.in_data = '0;
    b3.force_en = 1'b0; b3.force_sel = '0;
    b3.out_ready = 1'b1;
    repeat (3) cyc();

    chk("rst_valid", 32'(b4.out_valid), 0);
    chk("rst_data", b4.out_data, 0);
    chk("rst_sel", 32'(b4.out_sel), 0);
    chk("rst_ready", 32'(b4.in_ready), 0);
    chk("rst3_valid", 32'(b3.out_valid), 0);
    rst = 1'b0;
    cyc();
    chk("idle_ready", 32'(b4.in_ready), 0);
    chk("idle_valid", 32'(b4.out_valid), 0);

    // N=3 / WIDTH=8 build
    b3.in_data   = {8'h33, 8'h22, 8'h11};
    b3.in_valid  = 3'b111;
    b3.force_en  = 1'b1;
    b3.force_sel = 2'd3;
    #1 chk("n3_fsel3_ready", 32'(b3.in_ready), 0);
    cyc();
    chk("n3_fsel3_valid", 32'(b3.out_valid), 0);
    b3.force_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("n3_rr_ready", 32'(b3.in_ready),
             32'(1 << (k % 3)));
      cyc();
      chk("n3_rr_sel", 32'(b3.out_sel), 32'(k % 3));
      chk("n3_rr_data", 32'(b3.out_data),
          32'(8'h11 * ((k % 3) + 1)));
      chk("n3_rr_valid", 32'(b3.out_valid), 1);
    end
    b3.force_en  = 1'b1;
    b3.force_sel = 2'd2;
    #1 chk("n3_f2_ready", 32'(b3.in_ready), 32'b100);
    cyc();
    chk("n3_f2_data", 32'(b3.out_data), 32'h33);
    b3.in_valid = '0;
    b3.force_en = 1'b0;
    cyc();
    chk("n3_drain", 32'(b3.out_valid), 0);

    // Directed table on the N=4 build
    b4.in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tbl.push_back(vec_t'{4'hF,0,0,1,4'h1,1,0,32'hA0});
    tbl.push_back(vec_t'{4'hF,0,0,1,4'h2,1,1,32'hA1});
    tbl.push_back(vec_t'{4'hF,0,0,1,4'h4,1,2,32'hA2});
    tbl.push_back(vec_t'{4'hF,0,0,1,4'h8,1,3,32'hA3});
    tbl.push_back(vec_t'{4'hF,0,0,1,4'h1,1,0,32'hA0});
    tbl.push_back(vec_t'{4'hF,0,0,1,4'h2,1,1,32'hA1});
    for (int i = 0; i < 5; i++)
      tbl.push_back(vec_t'{4'hF,0,0,0,4'h0,1,1,32'hA1});
    tbl.push_back(vec_t'{4'hF,0,0,1,4'h4,1,2,32'hA2});
    for (int i = 0; i < 3; i++)
      tbl.push_back(vec_t'{4'hB,1,3,1,4'h8,1,3,32'hA3});
    tbl.push_back(vec_t'{4'hB,1,2,1,4'h0,0,3,32'hA3});
    tbl.push_back(vec_t'{4'hB,1,2,1,4'h0,0,3,32'hA3});
    tbl.push_back(vec_t'{4'h5,0,0,1,4'h1,1,0,32'hA0});
    tbl.push_back(vec_t'{4'h5,0,0,1,4'h4,1,2,32'hA2});
    tbl.push_back(vec_t'{4'h0,0,0,1,4'h0,0,2,32'hA2});
    tbl.push_back(vec_t'{4'h2,0,0,0,4'h2,1,1,32'hA1});
    tbl.push_back(vec_t'{4'h2,0,0,0,4'h0,1,1,32'hA1});

    foreach (tbl[i]) begin
      b4.in_valid  = tbl[i].v;
      b4.force_en  = tbl[i].fen;
      b4.force_sel = tbl[i].fsel;
      b4.out_ready = tbl[i].ordy;
      #1 chk($sformatf("tbl%0d_ready", i),
             32'(b4.in_ready), 32'(tbl[i].rdy));
      cyc();
      chk($sformatf("tbl%0d_valid", i),
          32'(b4.out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_sel", i),
          32'(b4.out_sel), 32'(tbl[i].os));
      chk($sformatf("tbl%0d_data", i),
          b4.out_data, tbl[i].od);
    end

    // Reset mid-stream clears the held word at once
    b4.in_valid  = 4'hF;
    b4.force_en  = 1'b0;
    b4.out_ready = 1'b1;
    cyc();
    chk("mid_pre_valid", 32'(b4.out_valid), 1);
    #2 rst = 1'b1;
    #1 chk("mid_rst_valid", 32'(b4.out_valid), 0);
    chk("mid_rst_data", b4.out_data, 0);
    cyc();
    rst = 1'b0;
    b4.in_valid = 4'b0110;
    #1 chk("mid_first_ready", 32'(b4.in_ready), 32'b0010);
    cyc();
    chk("mid_first_sel", 32'(b4.out_sel), 1);
    chk("mid_first_data", b4.out_data, 32'hA1);

    // Randomized run against the reference model
    b4.in_valid = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    m_lg = 3; m_v = 0; m_d = 0; m_s = 0;
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [31:0] dv[4];
      for (int i = 0; i < 4; i++) begin
        dv[i] = $urandom();
        b4.in_data[i*32 +: 32] = dv[i];
      end
      b4.in_valid  = 4'($urandom_range(0, 15));
      b4.force_en  = ($urandom_range(0, 7) == 0);
      b4.force_sel = 2'($urandom_range(0, 3));
      b4.out_ready = ($urandom_range(0, 3) != 0);
      g = pick(b4.in_valid, b4.force_en,
               int'(b4.force_sel), b4.out_ready);
      #1 chk("rnd_ready", 32'(b4.in_ready),
             (g < 0) ? 32'd0 : 32'(1 << g));
      cyc();
      if (g >= 0) begin
        m_v = 1; m_d = dv[g]; m_s = g; m_lg = g;
      end else if (b4.out_ready) begin
        m_v = 0;
      end
      chk("rnd_valid", 32'(b4.out_valid), 32'(m_v));
      chk("rnd_sel", 32'(b4.out_sel), 32'(m_s));
      chk("rnd_data", b4.out_data, m_d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_n.md
# rr_mux_n

Parametrised N-channel, WIDTH-bit round-robin arbitrating multiplexer with valid/ready handshakes and a registered output stage. It replaces static 4:1 select muxes wherever several producers contend for one datapath consumer, for example the PC/ALU/load-data write-back sources, or the SPI TX path shared between CPU stores and DMA. A force mode lets control logic pin the selection exactly as a static mux would, while keeping flow control.

## Interface
- WIDTH, 32, data width of every channel and of the output
- N, 4, number of input channels (N >= 2)
- SEL_W, derived = max(1, clog2(N)), width of select/index signals
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  N  per-channel request; bit i belongs to channel i
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel accept; at most one bit high per cycle
- force_en  in  1  1 = bypass arbitration and use force_sel
- force_sel  in  SEL_W  forced channel index
- out_valid  out  1  output register holds a valid word
- out_data  out  WIDTH  registered output word
- out_sel  out  SEL_W  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- Reset is asynchronous and active-high. While rst is high: out_valid=0, out_data=0, out_sel=0, last_grant pointer=N-1 (channel 0 has first priority). in_ready is combinational and therefore 0 while out_valid=0 and no requests are present.
- can_load = !out_valid || out_ready. The output stage is a single register; there is no skid buffer.
- Arbitration (force_en=0): if can_load, the grant goes to the first channel with in_valid set, searching circularly from last_grant+1. Only that channel's in_ready is asserted.
- Forced mode (force_en=1): if can_load and in_valid[force_sel] is set, in_ready[force_sel]=1. Otherwise no grant is made. If force_sel >= N, nothing is granted. last_grant is still updated on a forced transfer.
- Transfer on channel g means in_valid[g] && in_ready[g] at a clock edge. On that edge: out_data<=in_data[g], out_sel<=g, out_valid<=1, last_grant<=g.
- Output drain: out_valid && out_ready with no new transfer gives out_valid<=0. out_data and out_sel hold their last values.
- Simultaneous drain and load in the same cycle is allowed and sustains full throughput of one word per cycle.
- Stall: out_valid && !out_ready forces all in_ready to 0. out_data and out_sel must be held stable.
- A channel's in_valid may drop without a transfer; no request is latched.

## Timing
- Latency: 1 cycle from an accepted input to out_valid/out_data.
- in_ready depends combinationally on in_valid, force_en, force_sel, out_valid and out_ready. There is no combinational path from in_data to any output.
- Throughput: 1 word/cycle while out_ready=1.
- Fairness: with all N channels continuously requesting and out_ready=1, grants rotate 0,1,…,N-1,0. Any requesting channel is served within N transfers.
- A reset asserted mid-stream drops the held word immediately (asynchronous clear). The first grant after reset release goes to the lowest-indexed requester.

## Structure
- Shared package rv_pkg: SEL_W computation function (clog2 with minimum 1) and a one-hot-to-index function. No block-specific typedefs are needed.
- Sub-module rr_arbiter (parameter N): inputs req[N] and last_grant. Output is a one-hot grant computed by a rotate / priority-encode / rotate-back scheme. The top level adds force masking, the can_load gate and the output register.

## Test plan
- Reset, then no requests: out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Drive in_valid=1111 with data 0xA0..0xA3, out_ready=1: out_sel sequence is 0,1,2,3,0; out_data follows; one word per cycle; out_valid stays 1.
- out_ready=0 while out_valid=1 with data 0xA1 held: in_ready=0000 and out_data stable at 0xA1 for 5 cycles. Release: the next grant is channel 2.
- force_en=1, force_sel=3, in_valid=1011: only channel 3 is granted repeatedly. force_sel=2 with in_valid[2]=0 gives no grant and out_valid drops after the drain.
- N=3, WIDTH=8 build, force_sel=3: no grant. Round-robin over 0,1,2 verified, with correct per-channel data slicing.
- Assert rst for 1 cycle mid-stream while out_valid=1: out_valid falls immediately. After release with in_valid=0110, the first grant is channel 1.
